// File: rtl/lfsr_voice_bank_if.sv
// lfsr_voice_bank_if
//   Groups the configuration write port and the sample output handshake of
//   lfsr_voice_bank.
//   Config:  cfg_we, cfg_addr, cfg_div, cfg_taps, cfg_dir, cfg_seed
//   Sample:  sample_data, sample_valid (producer -> consumer), sample_ready (consumer -> producer)
//   Handshake: a snapshot transfers on a rising clk edge where sample_valid
//   and sample_ready are both high; while sample_valid is high and
//   sample_ready is low, sample_data holds its value.
//   Modports: slave  = the voice bank (receives config, produces samples)
//             master = the host/codec side (drives config, consumes samples)
interface lfsr_voice_bank_if #(
    parameter int CHANNELS   = 2,
    parameter int DEPTH      = 8,
    parameter int DIV_WIDTH  = 24,
    parameter int ADDR_WIDTH = 1
);
    logic                        cfg_we;
    logic [ADDR_WIDTH-1:0]       cfg_addr;
    logic [DIV_WIDTH-1:0]        cfg_div;
    logic [DEPTH-1:0]            cfg_taps;
    logic                        cfg_dir;
    logic [DEPTH-1:0]            cfg_seed;
    logic [CHANNELS*DEPTH-1:0]   sample_data;
    logic                        sample_valid;
    logic                        sample_ready;

    modport master (
        output cfg_we, cfg_addr, cfg_div, cfg_taps, cfg_dir, cfg_seed, sample_ready,
        input  sample_data, sample_valid
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_div, cfg_taps, cfg_dir, cfg_seed, sample_ready,
        output sample_data, sample_valid
    );
endinterface

// File: rtl/lfsr_voice_bank.sv
// lfsr_voice_bank
//   Bank of CHANNELS independent DEPTH-bit Fibonacci LFSR noise voices. Each
//   voice has its own step divider, tap mask, direction and seed, all
//   writable at runtime. Stepping in reverse is the exact inverse of forward
//   stepping when the top tap bit is set. The all-zero state is never
//   entered. Every edge on which at least one voice steps offers a snapshot
//   of all voices on a valid/ready port; a step that finds the previous
//   snapshot still unaccepted sets a sticky overrun flag.
// Ports
//   clk        - rising-edge clock
//   reset      - synchronous, active-low
//   enable     - 1 = dividers run, 0 = counters and LFSRs frozen
//   ovr_clr    - clears overrun (a coincident set wins)
//   bus        - config write port and sample handshake (slave side)
//   step_pulse - per-voice one-cycle pulse, high while the new value is visible
//   overrun    - sticky: a step happened while a snapshot was unaccepted
//   status     - MSB of voice 0 divider counter (heartbeat)
module lfsr_voice_bank #(
    parameter int               CHANNELS   = 2,
    parameter int               DEPTH      = 8,
    parameter int               DIV_WIDTH  = 24,
    parameter int               ADDR_WIDTH = 1,
    parameter logic [DEPTH-1:0] DEF_TAPS   = 'hB8,
    parameter logic [DEPTH-1:0] DEF_SEED   = 'h01
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  ovr_clr,
    lfsr_voice_bank_if.slave      bus,
    output logic [CHANNELS-1:0]   step_pulse,
    output logic                  overrun,
    output logic                  status
);

    localparam logic [DEPTH-1:0] ONE = {{(DEPTH-1){1'b0}}, 1'b1};

    // Zero is the lockup state of an XOR LFSR, so it is replaced by 1.
    function automatic logic [DEPTH-1:0] zero_guard(input logic [DEPTH-1:0] v);
        return (v == '0) ? ONE : v;
    endfunction

    function automatic logic [DEPTH-1:0] step_fwd(input logic [DEPTH-1:0] v,
                                                  input logic [DEPTH-1:0] t);
        return {v[DEPTH-2:0], ^(v & t)};
    endfunction

    // Undoes step_fwd: the bit shifted out at the top is recovered from the
    // feedback bit now in v[0] and the remaining tapped bits.
    function automatic logic [DEPTH-1:0] step_rev(input logic [DEPTH-1:0] v,
                                                  input logic [DEPTH-1:0] t);
        return {v[0] ^ (^(v[DEPTH-1:1] & t[DEPTH-2:0])), v[DEPTH-1:1]};
    endfunction

    logic [DIV_WIDTH-1:0]      cnt_q   [CHANNELS];
    logic [DIV_WIDTH-1:0]      cnt_d   [CHANNELS];
    logic [DIV_WIDTH-1:0]      div_q   [CHANNELS];
    logic [DIV_WIDTH-1:0]      div_d   [CHANNELS];
    logic [DEPTH-1:0]          taps_q  [CHANNELS];
    logic [DEPTH-1:0]          taps_d  [CHANNELS];
    logic [DEPTH-1:0]          lfsr_q  [CHANNELS];
    logic [DEPTH-1:0]          lfsr_d  [CHANNELS];
    logic [CHANNELS-1:0]       dir_q;
    logic [CHANNELS-1:0]       dir_d;
    logic [CHANNELS-1:0]       step_pulse_q;
    logic [CHANNELS-1:0]       step_pulse_d;
    logic [CHANNELS*DEPTH-1:0] sample_data_q;
    logic [CHANNELS*DEPTH-1:0] sample_data_d;
    logic                      sample_valid_q;
    logic                      sample_valid_d;
    logic                      overrun_q;
    logic                      overrun_d;

    logic [CHANNELS-1:0]       wr_hit;
    logic [CHANNELS*DEPTH-1:0] snap;

    always_comb begin
        wr_hit         = '0;
        step_pulse_d   = '0;
        snap           = '0;
        dir_d          = dir_q;
        sample_data_d  = sample_data_q;
        sample_valid_d = sample_valid_q;
        overrun_d      = ovr_clr ? 1'b0 : overrun_q;

        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i]  = cnt_q[i];
            div_d[i]  = div_q[i];
            taps_d[i] = taps_q[i];
            lfsr_d[i] = lfsr_q[i];

            // Out-of-range addresses never match any voice and are dropped.
            wr_hit[i] = bus.cfg_we && (int'(bus.cfg_addr) == i);

            if (wr_hit[i]) begin
                // A write takes precedence over a step due on the same edge.
                div_d[i]  = bus.cfg_div;
                taps_d[i] = bus.cfg_taps;
                dir_d[i]  = bus.cfg_dir;
                lfsr_d[i] = zero_guard(bus.cfg_seed);
                cnt_d[i]  = '0;
            end else if (enable) begin
                if (cnt_q[i] == div_q[i]) begin
                    cnt_d[i]        = '0;
                    step_pulse_d[i] = 1'b1;
                    lfsr_d[i]       = dir_q[i] ? zero_guard(step_rev(lfsr_q[i], taps_q[i]))
                                               : zero_guard(step_fwd(lfsr_q[i], taps_q[i]));
                end else begin
                    cnt_d[i] = cnt_q[i] + DIV_WIDTH'(1);
                end
            end

            snap[i*DEPTH +: DEPTH] = lfsr_d[i];
        end

        if (|step_pulse_d) begin
            if (!sample_valid_q || bus.sample_ready) begin
                sample_data_d  = snap;
                sample_valid_d = 1'b1;
            end else begin
                // Set after the clear above so it wins a coincident ovr_clr.
                overrun_d = 1'b1;
            end
        end else if (sample_valid_q && bus.sample_ready) begin
            sample_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]  <= '0;
                div_q[i]  <= '1;
                taps_q[i] <= DEF_TAPS;
                lfsr_q[i] <= zero_guard(DEF_SEED);
                dir_q[i]  <= ((i % 2) == 1);
            end
            step_pulse_q   <= '0;
            sample_data_q  <= '0;
            sample_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]  <= cnt_d[i];
                div_q[i]  <= div_d[i];
                taps_q[i] <= taps_d[i];
                lfsr_q[i] <= lfsr_d[i];
            end
            dir_q          <= dir_d;
            step_pulse_q   <= step_pulse_d;
            sample_data_q  <= sample_data_d;
            sample_valid_q <= sample_valid_d;
            overrun_q      <= overrun_d;
        end
    end

    assign step_pulse       = step_pulse_q;
    assign overrun          = overrun_q;
    assign status           = cnt_q[0][DIV_WIDTH-1];
    assign bus.sample_data  = sample_data_q;
    assign bus.sample_valid = sample_valid_q;

endmodule

// File: tb/tb_lfsr_voice_bank.sv
module tb_lfsr_voice_bank;

    localparam int CH = 2;
    localparam int D  = 8;
    localparam int DW = 24;
    localparam int AW = 1;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic          ovr_clr;
    logic [CH-1:0] step_pulse;
    logic          overrun;
    logic          status;

    lfsr_voice_bank_if #(.CHANNELS(CH), .DEPTH(D), .DIV_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    lfsr_voice_bank #(
        .CHANNELS(CH), .DEPTH(D), .DIV_WIDTH(DW), .ADDR_WIDTH(AW),
        .DEF_TAPS(8'hB8), .DEF_SEED(8'h01)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .enable     (enable),
        .ovr_clr    (ovr_clr),
        .bus        (bus),
        .step_pulse (step_pulse),
        .overrun    (overrun),
        .status     (status)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [D-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Voices are kept as plain integers; stepping is done with arithmetic
    // (shift = *2 mod 256, parity = popcount mod 2) and reverse stepping is
    // found by searching for the predecessor under the forward rule.
    int m_cnt  [CH];
    int m_div  [CH];
    int m_taps [CH];
    int m_dir  [CH];
    int m_val  [CH];
    int m_pulse[CH];
    int m_data [CH];
    int m_valid;
    int m_ovr;

    function automatic int m_guard(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int m_fwd(input int v, input int t);
        logic [7:0] vt;
        vt = 8'(v & t);
        return (v * 2) % 256 + ($countones(vt) % 2);
    endfunction

    function automatic int m_rev(input int v, input int t);
        logic [7:0] low;
        if (t >= 128) begin
            for (int u = 0; u < 256; u++)
                if (m_fwd(u, t) == v) return u;
            return -1;
        end
        low = 8'((v / 2) & (t % 128));
        return (((v % 2) ^ ($countones(low) % 2)) * 128) + v / 2;
    endfunction

    task automatic model_edge();
        int any_step;
        int ovr_next;
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                m_cnt[i] = 0;  m_div[i] = (1 << DW) - 1; m_taps[i] = 'hB8;
                m_val[i] = 1;  m_dir[i] = i % 2;          m_pulse[i] = 0;
                m_data[i] = 0;
            end
            m_valid = 0;
            m_ovr   = 0;
            return;
        end
        any_step = 0;
        for (int i = 0; i < CH; i++) begin
            m_pulse[i] = 0;
            if (bus.cfg_we && int'(bus.cfg_addr) == i) begin
                m_div[i]  = int'(bus.cfg_div);
                m_taps[i] = int'(bus.cfg_taps);
                m_dir[i]  = int'(bus.cfg_dir);
                m_val[i]  = m_guard(int'(bus.cfg_seed));
                m_cnt[i]  = 0;
            end else if (enable) begin
                if (m_cnt[i] == m_div[i]) begin
                    m_cnt[i]   = 0;
                    m_val[i]   = m_guard(m_dir[i] ? m_rev(m_val[i], m_taps[i])
                                                  : m_fwd(m_val[i], m_taps[i]));
                    m_pulse[i] = 1;
                    any_step   = 1;
                end else begin
                    m_cnt[i]++;
                end
            end
        end
        ovr_next = (m_ovr && !ovr_clr) ? 1 : 0;
        if (any_step) begin
            if (!m_valid || bus.sample_ready) begin
                for (int i = 0; i < CH; i++) m_data[i] = m_val[i];
                m_valid = 1;
            end else begin
                ovr_next = 1;
            end
        end else if (m_valid && bus.sample_ready) begin
            m_valid = 0;
        end
        m_ovr = ovr_next;
    endtask

    task automatic compare_all();
        check("step_pulse",   32'(step_pulse),       32'(m_pulse[1] * 2 + m_pulse[0]));
        check("sample_data",  32'(bus.sample_data),  32'(m_data[1] * 256 + m_data[0]));
        check("sample_valid", 32'(bus.sample_valid), 32'(m_valid));
        check("overrun",      32'(overrun),          32'(m_ovr));
        check("status",       32'(status),           32'((m_cnt[0] >> (DW - 1)) & 1));
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the active edge; outputs are sampled there too.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic cfg_write(input int addr, input int div, input int taps,
                             input int dir, input int seed);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = AW'(addr);
        bus.cfg_div  = DW'(div);
        bus.cfg_taps = D'(taps);
        bus.cfg_dir  = 1'(dir);
        bus.cfg_seed = D'(seed);
        cycle();
        bus.cfg_we   = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int x;
        int guard_cycles;
        logic [15:0] held;

        rst_n            = 1'b0;
        enable           = 1'b0;
        ovr_clr          = 1'b0;
        bus.cfg_we       = 1'b0;
        bus.cfg_addr     = '0;
        bus.cfg_div      = '0;
        bus.cfg_taps     = '0;
        bus.cfg_dir      = 1'b0;
        bus.cfg_seed     = '0;
        bus.sample_ready = 1'b1;
        #1;
        run(2);
        check("reset_valid", 32'(bus.sample_valid), 32'd0);
        check("reset_data",  32'(bus.sample_data),  32'd0);
        rst_n = 1'b1;

        // Voice 0 forward sequence with divider 3.
        enable = 1'b1;
        cfg_write(0, 3, 'hB8, 0, 'h01);
        exp_q = '{8'h02, 8'h04, 8'h08, 8'h11};
        for (int k = 0; k < 16; k++) begin
            cycle();
            if (m_pulse[0] != 0) begin
                if (exp_q.size() == 0) check("s1_extra_step", 32'(step_pulse[0]), 32'd0);
                else check("s1_seq", 32'(bus.sample_data[7:0]), 32'(exp_q.pop_front()));
            end
        end
        check("s1_all_steps_seen", 32'(exp_q.size()), 32'd0);

        // Voice 1 reverse from 0x11 gives 0x08.
        cfg_write(1, 0, 'hB8, 1, 'h11);
        cycle();
        check("s2_rev_first", 32'(bus.sample_data[15:8]), 32'h08);

        // Forward N then reverse N returns to the seed.
        cfg_write(1, 0, 'hB8, 0, 'h11);
        run(6);
        x = m_val[1];
        cfg_write(1, 0, 'hB8, 1, x);
        run(6);
        check("s2_round_trip", 32'(bus.sample_data[15:8]), 32'h11);

        // Zero seed loads as 1; a zero next value is replaced by 1.
        cfg_write(1, 7, 'hB8, 0, 'h00);
        run(4);
        check("s3_zero_seed", 32'(bus.sample_data[15:8]), 32'h01);
        cfg_write(1, 0, 'h01, 0, 'h80);
        cycle();
        check("s3_zero_next", 32'(bus.sample_data[15:8]), 32'h01);

        // Consumer stalls across several steps: data held, overrun set.
        cfg_write(1, 50, 'hB8, 1, 'h11);
        run(4);
        bus.sample_ready = 1'b0;
        cycle();
        held = bus.sample_data;
        run(10);
        check("s4_data_held", 32'(bus.sample_data), 32'(held));
        check("s4_overrun_set", 32'(overrun), 32'd1);
        enable  = 1'b0;
        ovr_clr = 1'b1;
        cycle();
        ovr_clr = 1'b0;
        check("s4_overrun_clr", 32'(overrun), 32'd0);
        enable = 1'b1;
        bus.sample_ready = 1'b1;

        // Config write on the step cycle of voice 0 suppresses that step.
        guard_cycles = 0;
        while (m_cnt[0] != m_div[0] && guard_cycles < 20) begin
            cycle();
            guard_cycles++;
        end
        check("s5_reached_step_cycle", 32'(m_cnt[0] == m_div[0]), 32'd1);
        cfg_write(0, 3, 'hB8, 0, 'h5A);
        check("s5_no_pulse", 32'(step_pulse[0]), 32'd0);
        run(3);
        check("s5_still_no_pulse", 32'(step_pulse[0]), 32'd0);
        cycle();
        check("s5_restart_pulse", 32'(step_pulse[0]), 32'd1);
        check("s5_seed_stepped", 32'(bus.sample_data[7:0]), 32'(m_fwd('h5A, 'hB8)));

        // Enable low freezes everything.
        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            check("s6_no_pulse", 32'(step_pulse), 32'd0);
        end
        enable = 1'b1;
        run(5);
        rst_n      = 1'b0;
        bus.cfg_we = 1'b1;
        cycle();
        bus.cfg_we = 1'b0;
        rst_n      = 1'b1;
        check("s6_reset_valid", 32'(bus.sample_valid), 32'd0);
        check("s6_reset_data",  32'(bus.sample_data),  32'd0);
        check("s6_reset_ovr",   32'(overrun),          32'd0);

        // Randomized traffic against the model.
        for (int k = 0; k < 2000; k++) begin
            bus.cfg_we = ($urandom_range(0, 9) == 0);
            if (bus.cfg_we) begin
                bus.cfg_addr = AW'($urandom_range(0, 1));
                bus.cfg_div  = DW'($urandom_range(0, 4));
                bus.cfg_taps = D'($urandom_range(0, 3) == 0 ? $urandom_range(0, 255)
                                                            : ($urandom_range(0, 255) | 'h80));
                bus.cfg_dir  = 1'($urandom_range(0, 1));
                bus.cfg_seed = D'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(0, 255));
            end
            enable           = ($urandom_range(0, 9) != 0);
            bus.sample_ready = ($urandom_range(0, 9) < 6);
            ovr_clr          = ($urandom_range(0, 19) == 0);
            rst_n            = ($urandom_range(0, 199) != 0);
            cycle();
        end
        bus.cfg_we = 1'b0;
        rst_n      = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
